// File: rtl/regfile_write_arbiter.sv
// rtl/regfile_write_arbiter.sv - two-requester register-file write port arbiter with per-requester holding slots
// REGFILE_ARB_BYPASS_EN: a slot that wins this cycle may also accept a new write at the same edge.
module regfile_write_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req0Valid,
  output logic                  req0Ready,
  input  logic [ADDR_WIDTH-1:0] req0Rd,
  input  logic [DATA_WIDTH-1:0] req0Data,
  input  logic                  req1Valid,
  output logic                  req1Ready,
  input  logic [ADDR_WIDTH-1:0] req1Rd,
  input  logic [DATA_WIDTH-1:0] req1Data,
  output logic                  writeEnable,
  output logic [ADDR_WIDTH-1:0] desRegister,
  output logic [DATA_WIDTH-1:0] writeData,
  output logic                  grantId
);

  logic                  full0_q, full0_d, full1_q, full1_d;
  logic [ADDR_WIDTH-1:0] rd0_q, rd0_d, rd1_q, rd1_d;
  logic [DATA_WIDTH-1:0] data0_q, data0_d, data1_q, data1_d;
  // age_q names the slot that wins when both are full (0 = slot0, 1 = slot1)
  logic                  age_q, age_d;
  logic                  rr_q, rr_d;

  logic grant0, grant1;
  logic load0, load1;
  logic stay0, stay1;

  always_comb begin
    grant1 = full1_q & (~full0_q | age_q);
    grant0 = full0_q & ~grant1;
  end

  always_comb begin
    writeEnable = full0_q | full1_q;
    grantId     = grant1;
    desRegister = '0;
    writeData   = '0;
    if (grant1) begin
      desRegister = rd1_q;
      writeData   = data1_q;
    end else if (grant0) begin
      desRegister = rd0_q;
      writeData   = data0_q;
    end
  end

`ifdef REGFILE_ARB_BYPASS_EN
  always_comb begin
    req0Ready = ~full0_q | grant0;
    req1Ready = ~full1_q | grant1;
  end
`else
  always_comb begin
    req0Ready = ~full0_q;
    req1Ready = ~full1_q;
  end
`endif

  // Writes to x0 complete the handshake but never occupy a slot
  always_comb begin
    load0 = req0Valid & req0Ready & (req0Rd != '0);
    load1 = req1Valid & req1Ready & (req1Rd != '0);
    stay0 = full0_q & ~grant0;
    stay1 = full1_q & ~grant1;
  end

  always_comb begin
    full0_d = stay0 | load0;
    full1_d = stay1 | load1;
    rd0_d   = load0 ? req0Rd   : rd0_q;
    data0_d = load0 ? req0Data : data0_q;
    rd1_d   = load1 ? req1Rd   : rd1_q;
    data1_d = load1 ? req1Data : data1_q;
  end

  // A simultaneous load can only land in two empty slots, so it is a true tie
  always_comb begin
    age_d = age_q;
    rr_d  = rr_q;
    if (load0 && load1) begin
      age_d = rr_q;
      rr_d  = ~rr_q;
    end else if (load0) begin
      age_d = stay1;
    end else if (load1) begin
      age_d = ~stay0;
    end else if (grant0 || grant1) begin
      age_d = stay1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full0_q <= 1'b0;
      full1_q <= 1'b0;
      rd0_q   <= '0;
      rd1_q   <= '0;
      data0_q <= '0;
      data1_q <= '0;
      age_q   <= 1'b0;
      rr_q    <= 1'b0;
    end else begin
      full0_q <= full0_d;
      full1_q <= full1_d;
      rd0_q   <= rd0_d;
      rd1_q   <= rd1_d;
      data0_q <= data0_d;
      data1_q <= data1_d;
      age_q   <= age_d;
      rr_q    <= rr_d;
    end
  end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb/tb_regfile_write_arbiter.sv - scoreboard bench for regfile_write_arbiter
module tb_regfile_write_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0Valid, req0Ready, req1Valid, req1Ready;
  logic [4:0]  req0Rd, req1Rd, desRegister;
  logic [31:0] req0Data, req1Data, writeData;
  logic        writeEnable, grantId;

  logic [31:0] rf [32];
  logic [37:0] exp_q [$];
  int          n_cmp  = 0;
  int          n_fail = 0;

  regfile_write_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
    .clk(clk), .rst(rst),
    .req0Valid(req0Valid), .req0Ready(req0Ready), .req0Rd(req0Rd), .req0Data(req0Data),
    .req1Valid(req1Valid), .req1Ready(req1Ready), .req1Rd(req1Rd), .req1Data(req1Data),
    .writeEnable(writeEnable), .desRegister(desRegister), .writeData(writeData),
    .grantId(grantId)
  );

  always #5 clk = ~clk;

  initial for (int i = 0; i < 32; i++) rf[i] = '0;

  always @(posedge clk) if (writeEnable) rf[desRegister] <= writeData;

  always @(negedge clk) begin
    logic [37:0] e;
    if (!rst && writeEnable) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_write: got grant=%0d rd=%0d data=%h, required no write",
                 grantId, desRegister, writeData);
      end else begin
        e = exp_q.pop_front();
        if ({grantId, desRegister, writeData} !== e) begin
          n_fail++;
          $display("FAIL port_write: got grant=%0d rd=%0d data=%h, required grant=%0d rd=%0d data=%h",
                   grantId, desRegister, writeData, e[37], e[36:32], e[31:0]);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
    n_cmp++;
    if (got !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, got, req);
    end
  endtask

  task automatic push(input logic g, input logic [4:0] rd, input logic [31:0] d);
    exp_q.push_back({g, rd, d});
  endtask

  task automatic drive(input logic v0, input logic [4:0] rd0, input logic [31:0] d0,
                       input logic v1, input logic [4:0] rd1, input logic [31:0] d1);
    req0Valid = v0; req0Rd = rd0; req0Data = d0;
    req1Valid = v1; req1Rd = rd1; req1Data = d1;
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    drive(0, 0, 0, 0, 0, 0);
    repeat (n) cycle();
  endtask

  initial begin
    int acc;
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    repeat (2) cycle();
    check("rst_writeEnable", {31'b0, writeEnable}, 32'd0);
    check("rst_desRegister", {27'b0, desRegister}, 32'd0);
    check("rst_writeData", writeData, 32'd0);
    check("rst_grantId", {31'b0, grantId}, 32'd0);
    check("rst_req0Ready", {31'b0, req0Ready}, 32'd1);
    check("rst_req1Ready", {31'b0, req1Ready}, 32'd1);
    rst = 1'b0;

    // single write, accepted at the first edge after reset release
    push(0, 5'd5, 32'h11);
    drive(1, 5'd5, 32'h11, 0, 0, 0);
    cycle();
    idle(3);
    check("rf5", rf[5], 32'h11);

    // simultaneous accepts: round-robin, then pointer flipped
    push(0, 5'd3, 32'hA); push(1, 5'd4, 32'hB);
    drive(1, 5'd3, 32'hA, 1, 5'd4, 32'hB);
    cycle();
    idle(3);
    push(1, 5'd4, 32'hB); push(0, 5'd3, 32'hA);
    drive(1, 5'd3, 32'hA, 1, 5'd4, 32'hB);
    cycle();
    idle(3);

    // same destination: requester 1 first, requester 0 last
    push(1, 5'd7, 32'h71); push(0, 5'd7, 32'h70);
    drive(0, 0, 0, 1, 5'd7, 32'h71);
    cycle();
    drive(1, 5'd7, 32'h70, 0, 0, 0);
    cycle();
    idle(3);
    check("rf7", rf[7], 32'h70);

    // x0 write is accepted but never reaches the port
    drive(1, 5'd0, 32'hFF, 0, 0, 0);
    check("x0_ready", {31'b0, req0Ready}, 32'd1);
    cycle();
    check("x0_writeEnable", {31'b0, writeEnable}, 32'd0);
    idle(3);
    check("rf0", rf[0], 32'h0);

    // back-to-back requests from requester 0
`ifdef REGFILE_ARB_BYPASS_EN
    for (int i = 0; i < 4; i++) push(0, 5'(8 + i), 32'h80 + i);
`else
    push(0, 5'd8, 32'h80); push(0, 5'd10, 32'h82);
`endif
    acc = 0;
    for (int i = 0; i < 4; i++) begin
      drive(1, 5'(8 + i), 32'h80 + i, 0, 0, 0);
      if (req0Ready) acc++;
      cycle();
    end
    idle(3);
`ifdef REGFILE_ARB_BYPASS_EN
    check("b2b_accepts", acc, 32'd4);
`else
    check("b2b_accepts", acc, 32'd2);
`endif

    // reset pulse with both slots full discards them
    drive(1, 5'd12, 32'hC0, 1, 5'd13, 32'hD0);
    cycle();
    drive(0, 0, 0, 0, 0, 0);
    check("full_writeEnable", {31'b0, writeEnable}, 32'd1);
    rst = 1'b1;
    #1;
    check("pulse_writeEnable", {31'b0, writeEnable}, 32'd0);
    rst = 1'b0;
    #1;
    check("post_req0Ready", {31'b0, req0Ready}, 32'd1);
    check("post_req1Ready", {31'b0, req1Ready}, 32'd1);
    idle(4);
    check("rf12", rf[12], 32'h0);

    check("pending_writes", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
